// File: rtl/dpi_ctx_pkg.sv
// Shared FSM encoding, default sizes and counter helpers for the DPI stream context block.
// Build option DPI_COUNT_SATURATE_EN: match counters saturate instead of wrapping.
package dpi_ctx_pkg;

    localparam int DEF_NUM_STREAMS = 64;
    localparam int DEF_STATE_W     = 11;
    localparam int DEF_CNT_W       = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_RUN    = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_COMMIT = 3'd4,
        ST_CLEAR  = 3'd5
    } ctx_state_e;

    function automatic int sid_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic [31:0] cnt_limit(input int w);
        return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    endfunction

    // Next counter value; cnt_max is the all-ones value of the counter width.
    function automatic logic [31:0] cnt_next(input logic [31:0] cnt, input logic inc,
                                             input logic [31:0] cnt_max);
`ifdef DPI_COUNT_SATURATE_EN
        if (inc && (cnt != cnt_max)) begin
            return cnt + 32'd1;
        end else begin
            return cnt;
        end
`else
        return (cnt + {31'd0, inc}) & cnt_max;
`endif
    endfunction

endpackage

// File: rtl/dpi_stream_ctx_if.sv
// Engine-side bus of the DPI stream context block: context load, byte feed, engine result.
interface dpi_stream_ctx_if import dpi_ctx_pkg::*; #(
    parameter int STATE_W = DEF_STATE_W
);
    logic [STATE_W-1:0] eng_state_in;
    logic               eng_state_in_vld;
    logic [7:0]         eng_char_in;
    logic               eng_char_in_vld;
    logic [STATE_W-1:0] eng_state_out;
    logic               eng_accept_out;

    modport master (
        output eng_state_in, eng_state_in_vld, eng_char_in, eng_char_in_vld,
        input  eng_state_out, eng_accept_out
    );

    modport slave (
        input  eng_state_in, eng_state_in_vld, eng_char_in, eng_char_in_vld,
        output eng_state_out, eng_accept_out
    );
endinterface

// File: rtl/dpi_ctx_ram.sv
// Per-stream storage: saved matcher state, valid bits and matched-packet counts.
// One write port, a sync read for context load and a read-first sync read for rd_sid.
module dpi_ctx_ram import dpi_ctx_pkg::*; #(
    parameter int NUM_STREAMS = DEF_NUM_STREAMS,
    parameter int STATE_W     = DEF_STATE_W,
    parameter int CNT_W       = DEF_CNT_W,
    localparam int SID_W      = sid_width(NUM_STREAMS)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ld_en,
    input  logic [SID_W-1:0]   ld_sid,
    output logic [STATE_W-1:0] ld_state,
    output logic               ld_valid,
    input  logic               wr_en,
    input  logic [SID_W-1:0]   wr_sid,
    input  logic [STATE_W-1:0] wr_state,
    input  logic               wr_inc,
    input  logic               clr_en,
    input  logic [SID_W-1:0]   clr_sid,
    input  logic [SID_W-1:0]   rd_sid,
    output logic [CNT_W-1:0]   rd_count
);
    localparam logic [31:0] CNT_MAX = cnt_limit(CNT_W);

    logic [STATE_W-1:0]     state_tbl_r [NUM_STREAMS];
    logic [NUM_STREAMS-1:0] valid_r;
    logic [CNT_W-1:0]       count_r [NUM_STREAMS];

    // State table and its load read; contents are masked by valid_r so they carry no reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            state_tbl_r[wr_sid] <= wr_state;
        end
        if (ld_en) begin
            ld_state <= state_tbl_r[ld_sid];
        end
    end

    // Valid bits, per-stream counts and both registered read ports
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r  <= '0;
            ld_valid <= 1'b0;
            rd_count <= '0;
            for (int i = 0; i < NUM_STREAMS; i++) begin
                count_r[i] <= '0;
            end
        end else begin
            if (clr_en) begin
                valid_r[clr_sid] <= 1'b0;
            end else if (wr_en) begin
                valid_r[wr_sid] <= 1'b1;
            end
            if (wr_en) begin
                count_r[wr_sid] <= CNT_W'(cnt_next(32'(count_r[wr_sid]), wr_inc, CNT_MAX));
            end
            if (ld_en) begin
                ld_valid <= valid_r[ld_sid];
            end
            rd_count <= count_r[rd_sid];
        end
    end
endmodule

// File: rtl/dpi_stream_ctx.sv
// Multiplexes one pattern-matching engine across many packet streams by saving and
// restoring its state per stream and counting matched packets.
module dpi_stream_ctx import dpi_ctx_pkg::*; #(
    parameter int NUM_STREAMS = DEF_NUM_STREAMS,
    parameter int STATE_W     = DEF_STATE_W,
    parameter int CNT_W       = DEF_CNT_W,
    localparam int SID_W      = sid_width(NUM_STREAMS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sop,
    input  logic [SID_W-1:0] stream_id,
    input  logic             enable,
    input  logic [7:0]       char_in,
    input  logic             char_in_vld,
    input  logic             eop,
    input  logic             clear_all,
    dpi_stream_ctx_if.master eng,
    output logic             busy,
    output logic             fired,
    output logic [CNT_W-1:0] total_count,
    input  logic [SID_W-1:0] rd_sid,
    output logic [CNT_W-1:0] rd_count
);
    localparam logic [31:0]      CNT_MAX  = cnt_limit(CNT_W);
    localparam logic [SID_W-1:0] LAST_SID = SID_W'(NUM_STREAMS - 1);

    ctx_state_e         state_r;
    ctx_state_e         state_nxt;
    logic [SID_W-1:0]   cur_sid_r;
    logic [SID_W-1:0]   clr_idx_r;
    logic               en_r;
    logic               clr_pend_r;
    logic               fired_r;
    logic [CNT_W-1:0]   total_r;
    logic [STATE_W-1:0] ld_state_s;
    logic               ld_valid_s;
    logic               clr_req_s;
    logic               last_byte_s;
    logic               commit_wr_s;

    assign clr_req_s   = clear_all | clr_pend_r;
    assign last_byte_s = char_in_vld & eop;
    assign commit_wr_s = (state_r == ST_COMMIT) & en_r;
    assign fired       = fired_r;
    assign total_count = total_r;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt;
        end
    end

    // Next-state logic; a pending clear takes priority over a new packet
    always_comb begin
        state_nxt = state_r;
        case (state_r)
            ST_IDLE: begin
                if (clr_req_s) begin
                    state_nxt = ST_CLEAR;
                end else if (sop) begin
                    state_nxt = ST_LOAD;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_LOAD:   state_nxt = ST_RUN;
            ST_RUN: begin
                if (last_byte_s) begin
                    state_nxt = ST_DRAIN;
                end else begin
                    state_nxt = ST_RUN;
                end
            end
            ST_DRAIN:  state_nxt = ST_COMMIT;
            ST_COMMIT: state_nxt = ST_IDLE;
            ST_CLEAR: begin
                if (clr_idx_r == LAST_SID) begin
                    state_nxt = ST_IDLE;
                end else begin
                    state_nxt = ST_CLEAR;
                end
            end
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Output decode; payload bytes pass straight through only while running
    always_comb begin
        busy                 = (state_r != ST_IDLE);
        eng.eng_state_in_vld = (state_r == ST_LOAD);
        eng.eng_char_in_vld  = (state_r == ST_RUN) & char_in_vld;
        if ((state_r == ST_LOAD) && ld_valid_s) begin
            eng.eng_state_in = ld_state_s;
        end else begin
            eng.eng_state_in = '0;
        end
        if (state_r == ST_RUN) begin
            eng.eng_char_in = char_in;
        end else begin
            eng.eng_char_in = 8'd0;
        end
    end

    // Packet context, match flag, clear walker, pending clear and global counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_sid_r  <= '0;
            en_r       <= 1'b0;
            fired_r    <= 1'b0;
            clr_idx_r  <= '0;
            clr_pend_r <= 1'b0;
            total_r    <= '0;
        end else begin
            if ((state_r == ST_IDLE) && !clr_req_s && sop) begin
                cur_sid_r <= stream_id;
            end
            if ((state_r == ST_RUN) && last_byte_s) begin
                en_r <= enable;
            end
            if (state_r == ST_LOAD) begin
                fired_r <= 1'b0;
            end else if (((state_r == ST_RUN) || (state_r == ST_DRAIN)) && eng.eng_accept_out) begin
                fired_r <= 1'b1;
            end else if ((state_r == ST_COMMIT) && !en_r) begin
                fired_r <= 1'b0;
            end
            if (state_r == ST_CLEAR) begin
                clr_idx_r <= clr_idx_r + SID_W'(1);
            end else begin
                clr_idx_r <= '0;
            end
            if (state_r == ST_IDLE) begin
                clr_pend_r <= 1'b0;
            end else if (clear_all) begin
                clr_pend_r <= 1'b1;
            end
            if (commit_wr_s) begin
                total_r <= CNT_W'(cnt_next(32'(total_r), fired_r, CNT_MAX));
            end
        end
    end

    dpi_ctx_ram #(
        .NUM_STREAMS (NUM_STREAMS),
        .STATE_W     (STATE_W),
        .CNT_W       (CNT_W)
    ) u_ram (
        .clk      (clk),
        .rst_n    (rst_n),
        .ld_en    (state_r == ST_IDLE),
        .ld_sid   (stream_id),
        .ld_state (ld_state_s),
        .ld_valid (ld_valid_s),
        .wr_en    (commit_wr_s),
        .wr_sid   (cur_sid_r),
        .wr_state (eng.eng_state_out),
        .wr_inc   (fired_r),
        .clr_en   (state_r == ST_CLEAR),
        .clr_sid  (clr_idx_r),
        .rd_sid   (rd_sid),
        .rd_count (rd_count)
    );
endmodule

// File: tb/tb_dpi_stream_ctx.sv
// Bench for dpi_stream_ctx: directed scenarios plus random packets against a per-stream model.
module tb_dpi_stream_ctx;
    localparam int NS   = 64;
    localparam int SW   = 11;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk         = 1'b0;
    logic          rst_n       = 1'b0;
    logic          sop         = 1'b0;
    logic [5:0]    stream_id   = 6'd0;
    logic          enable      = 1'b0;
    logic [7:0]    char_in     = 8'd0;
    logic          char_in_vld = 1'b0;
    logic          eop         = 1'b0;
    logic          clear_all   = 1'b0;
    logic [5:0]    rd_sid      = 6'd0;
    logic          busy;
    logic          fired;
    logic [CW-1:0] total_count;
    logic [CW-1:0] rd_count;

    int total = 0;
    int bad   = 0;

    int m_state [NS];
    bit m_valid [NS];
    int m_cnt   [NS];
    int m_total;

    always #5 clk = ~clk;

    dpi_stream_ctx_if #(.STATE_W(SW)) eng_bus ();

    dpi_stream_ctx #(.NUM_STREAMS(NS), .STATE_W(SW), .CNT_W(CW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sop         (sop),
        .stream_id   (stream_id),
        .enable      (enable),
        .char_in     (char_in),
        .char_in_vld (char_in_vld),
        .eop         (eop),
        .clear_all   (clear_all),
        .eng         (eng_bus),
        .busy        (busy),
        .fired       (fired),
        .total_count (total_count),
        .rd_sid      (rd_sid),
        .rd_count    (rd_count)
    );

    function automatic int bump(input int c, input bit hit);
        if (!hit) return c;
`ifdef DPI_COUNT_SATURATE_EN
        return (c >= CMAX) ? CMAX : c + 1;
`else
        return (c + 1) % (CMAX + 1);
`endif
    endfunction

    function automatic void reset_model();
        for (int k = 0; k < NS; k++) begin
            m_valid[k] = 1'b0;
            m_cnt[k]   = 0;
        end
        m_total = 0;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic count_clear();
        int n;
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            n++;
            @(negedge clk);
        end
        check("clear_busy_cycles", 32'(n), 32'(NS));
        for (int k = 0; k < NS; k++) m_valid[k] = 1'b0;
    endtask

    // One full packet from IDLE back to IDLE; acc[i] = engine accept for byte i.
    task automatic run_pkt(input int sid, input int nbytes, input bit en, input int end_state,
                           input bit [7:0] acc, input bit sop_eop, input bit ign_sop, input bit clr_mid);
        int exp_load;
        int old_cnt;
        int i;
        int guard;
        bit hit;
        bit pend;
        exp_load = m_valid[sid] ? m_state[sid] : 0;
        hit = 1'b0;
        for (int k = 0; k < nbytes; k++) if (acc[k]) hit = 1'b1;
        stream_id   = 6'(sid);
        sop         = 1'b1;
        enable      = en;
        char_in_vld = sop_eop;
        eop         = sop_eop;
        #1 check("idle_no_fwd", 32'(eng_bus.eng_char_in_vld), 32'd0);
        @(negedge clk);
        sop         = 1'b0;
        eop         = 1'b0;
        char_in_vld = 1'b1;
        stream_id   = 6'($urandom_range(0, NS - 1));
        #1;
        check("load_vld", 32'(eng_bus.eng_state_in_vld), 32'd1);
        check("load_state", 32'(eng_bus.eng_state_in), 32'(exp_load));
        check("load_no_fwd", 32'(eng_bus.eng_char_in_vld), 32'd0);
        check("load_busy", 32'(busy), 32'd1);
        @(negedge clk);
        char_in_vld = 1'b0;
        check("run_fired_clr", 32'(fired), 32'd0);
        pend  = 1'b0;
        i     = 0;
        guard = 0;
        while (i < nbytes && guard < 100) begin
            guard++;
            eng_bus.eng_accept_out = pend;
            if (guard < 50 && $urandom_range(0, 3) == 0) begin
                char_in_vld = 1'b0;
                eop         = 1'b0;
                pend        = 1'b0;
            end else begin
                char_in     = 8'($urandom);
                char_in_vld = 1'b1;
                eop         = (i == nbytes - 1);
                pend        = acc[i];
                if (ign_sop && i == 0) begin
                    sop       = 1'b1;
                    stream_id = 6'(sid ^ 1);
                end
                if (clr_mid && i == 0) clear_all = 1'b1;
                #1;
                check("run_fwd_vld", 32'(eng_bus.eng_char_in_vld), 32'd1);
                check("run_fwd_data", 32'(eng_bus.eng_char_in), 32'(char_in));
                i++;
            end
            @(negedge clk);
            sop       = 1'b0;
            clear_all = 1'b0;
        end
        char_in_vld            = 1'b0;
        eop                    = 1'b0;
        eng_bus.eng_accept_out = pend;
        eng_bus.eng_state_out  = 11'(end_state);
        #1 check("drain_no_fwd", 32'(eng_bus.eng_char_in_vld), 32'd0);
        @(negedge clk);
        eng_bus.eng_accept_out = 1'b0;
        check("commit_fired", 32'(fired), 32'(hit));
        rd_sid  = 6'(sid);
        old_cnt = m_cnt[sid];
        @(negedge clk);
        check("rd_pre_update", 32'(rd_count), 32'(old_cnt));
        if (en) begin
            m_state[sid] = end_state;
            m_valid[sid] = 1'b1;
            m_cnt[sid]   = bump(m_cnt[sid], hit);
            m_total      = bump(m_total, hit);
        end
        check("total_count", 32'(total_count), 32'(m_total));
        check("fired_after", 32'(fired), en ? 32'(hit) : 32'd0);
        check("idle_after_commit", 32'(busy), 32'd0);
        @(negedge clk);
        check("rd_count", 32'(rd_count), 32'(m_cnt[sid]));
        if (clr_mid) begin
            count_clear();
        end else begin
            check("idle", 32'(busy), 32'd0);
        end
    endtask

    initial begin
        reset_model();
        for (int k = 0; k < NS; k++) m_state[k] = 0;
        eng_bus.eng_state_out  = 11'd0;
        eng_bus.eng_accept_out = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_fired", 32'(fired), 32'd0);
        check("rst_total", 32'(total_count), 32'd0);
        check("rst_load_vld", 32'(eng_bus.eng_state_in_vld), 32'd0);
        check("rst_char_vld", 32'(eng_bus.eng_char_in_vld), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_rd_count", 32'(rd_count), 32'd0);

        // New stream 5 with a mid-packet accept
        run_pkt(5, 4, 1'b1, 'h2A5, 8'b0000_0010, 1'b0, 1'b0, 1'b0);
        check("s1_total", 32'(total_count), 32'd1);
        check("s1_rd5", 32'(rd_count), 32'd1);
        // Restore of 0x2A5; accept only on the eop byte
        run_pkt(5, 3, 1'b1, 'h155, 8'b0000_0100, 1'b0, 1'b0, 1'b0);
        check("s3_total", 32'(total_count), 32'd2);
        // Disabled commit with accept
        run_pkt(5, 2, 1'b0, 'h3FF, 8'b0000_0011, 1'b0, 1'b0, 1'b0);
        check("s4_fired", 32'(fired), 32'd0);
        check("s4_total", 32'(total_count), 32'd2);
        // sop+eop in IDLE and sop while busy
        run_pkt(5, 2, 1'b1, 'h0AA, 8'b0000_0000, 1'b1, 1'b1, 1'b0);

        clear_all = 1'b1;
        @(negedge clk);
        clear_all = 1'b0;
        count_clear();
        rd_sid = 6'd5;
        @(negedge clk);
        check("clear_keeps_count", 32'(rd_count), 32'd2);
        run_pkt(5, 3, 1'b1, 'h011, 8'b0000_0001, 1'b0, 1'b0, 1'b0);

        for (int p = 0; p < 40; p++) begin
            run_pkt($urandom_range(0, 7), $urandom_range(1, 6), 1'($urandom_range(0, 1)),
                    $urandom_range(0, 2047), 8'($urandom), $urandom_range(0, 7) == 0,
                    $urandom_range(0, 5) == 0, p == 20);
        end

        for (int p = 0; p < 17; p++) begin
            run_pkt(9, 1, 1'b1, 'h009, 8'b0000_0001, 1'b0, 1'b0, 1'b0);
        end
        rd_sid = 6'd9;
        @(negedge clk);
`ifdef DPI_COUNT_SATURATE_EN
        check("sat_count", 32'(rd_count), 32'd15);
`else
        check("wrap_count", 32'(rd_count), 32'd1);
`endif

        // Reset in the middle of a matching packet
        stream_id = 6'd5;
        sop       = 1'b1;
        enable    = 1'b1;
        @(negedge clk);
        sop = 1'b0;
        @(negedge clk);
        char_in     = 8'h41;
        char_in_vld = 1'b1;
        @(negedge clk);
        eng_bus.eng_accept_out = 1'b1;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_fired", 32'(fired), 32'd0);
        check("mid_rst_total", 32'(total_count), 32'd0);
        check("mid_rst_char_vld", 32'(eng_bus.eng_char_in_vld), 32'd0);
        reset_model();
        char_in_vld            = 1'b0;
        eng_bus.eng_accept_out = 1'b0;
        @(negedge clk);
        rst_n  = 1'b1;
        rd_sid = 6'd5;
        @(negedge clk);
        check("mid_rst_rd5", 32'(rd_count), 32'd0);
        run_pkt(5, 2, 1'b1, 'h007, 8'b0000_0001, 1'b0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/dpi_stream_ctx.md
DPI_STREAM_CTX -- requirements
Module: dpi_stream_ctx

Interface
REQ-001 Parameter NUM_STREAMS, default 64, number of stream contexts (power of 2); SID_W = log2(NUM_STREAMS).
REQ-002 Parameter STATE_W, default 11, matcher state width.
REQ-003 Parameter CNT_W, default 16, match counter width.
REQ-004 Clock and reset: one clock; reset is asynchronous and active-low.
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
REQ-005 Packet inputs:
- sop  in  1  packet start.
- stream_id  in  SID_W  stream of the packet, sampled at sop.
- enable  in  1  matcher enabled for this stream, sampled at eop.
- char_in  in  8  payload byte.
- char_in_vld  in  1  byte valid.
- eop  in  1  last byte of packet, qualified by char_in_vld.
- clear_all  in  1  invalidate all stream contexts.
REQ-006 Engine interface:
- eng_state_in  out  STATE_W  context to load.
- eng_state_in_vld  out  1  context load strobe.
- eng_char_in  out  8  byte to engine.
- eng_char_in_vld  out  1  byte strobe to engine.
- eng_state_out  in  STATE_W  engine state.
- eng_accept_out  in  1  match, 1 cycle after the byte.
REQ-007 Status and readback:
- busy  out  1  not IDLE.
- fired  out  1  match seen in current packet.
- total_count  out  CNT_W  packets matched, all streams.
- rd_sid  in  SID_W  readback stream select.
- rd_count  out  CNT_W  matched-packet count of stream rd_sid, registered, 1-cycle latency.

Function
REQ-008 FSM states: IDLE, LOAD, RUN, DRAIN, COMMIT, CLEAR.
REQ-009 IDLE->LOAD on sop; latch stream_id into cur_sid.
REQ-010 LOAD, one cycle: pulse eng_state_in_vld; eng_state_in = saved state if the valid bit of cur_sid is set, else 0; clear fired; ->RUN.
REQ-011 RUN: eng_char_in/eng_char_in_vld = char_in/char_in_vld combinationally; char_in_vld with eop ->DRAIN.
REQ-012 Bytes outside RUN are not forwarded; eng_char_in_vld = 0.
REQ-013 eng_accept_out in RUN or DRAIN sets fired; fired is held until the next LOAD.
REQ-014 DRAIN, one cycle: captures the accept of the last byte; ->COMMIT.
REQ-015 COMMIT with enable = 1: write eng_state_out to the state table; set valid[cur_sid]; add fired (0/1) to total_count and count[cur_sid]. The increment includes an accept arriving in DRAIN.
REQ-016 COMMIT with enable = 0: no table or count update; fired cleared.
REQ-017 Every COMMIT ->IDLE.
REQ-018 sop while busy is ignored; the source must wait for busy = 0.
REQ-019 sop and eop in the same cycle while in IDLE: treated as sop only.
REQ-020 clear_all in IDLE ->CLEAR: clear one valid bit per cycle, index 0..NUM_STREAMS-1, then ->IDLE. busy stays high throughout.
REQ-021 clear_all outside IDLE is held pending and taken at the next IDLE.
REQ-022 Counts are unaffected by CLEAR.
REQ-023 Per-stream count and total_count update in the same COMMIT cycle.
REQ-024 A read of the stream being committed returns the pre-update value.

Reset
REQ-025 rst_n low asynchronously forces: state IDLE; fired, busy, eng_state_in_vld, eng_char_in_vld = 0; total_count = 0; all valid bits = 0; all per-stream counts = 0; pending clear = 0.
REQ-026 State table contents are not reset; they are masked by the valid bits.
REQ-027 Reset mid-packet abandons the packet with no update.

Configuration
REQ-028 With DPI_COUNT_SATURATE_EN defined, total_count and per-stream counts saturate at 2^CNT_W-1.
REQ-029 Without DPI_COUNT_SATURATE_EN, counts wrap modulo 2^CNT_W.

Structure
REQ-030 Shared package dpi_ctx_pkg holds the FSM state enum, default parameter constants and the SID_W derivation.
REQ-031 Sub-module dpi_ctx_ram holds the state table, valid bits and per-stream counts: one write port, one sync read port for context load, one sync read port for rd_sid.

Verification
REQ-032 Bench covers these directed scenarios:
- New stream 5, packet with an accept, enable = 1 -> LOAD gives eng_state_in = 0; after COMMIT total_count = 1, rd_count(5) = 1, valid[5] = 1.
- Engine ends packet on stream 5 with eng_state_out = 0x2A5, then second packet on stream 5 -> LOAD drives eng_state_in = 0x2A5.
- Accept only on the eop byte (arrives in DRAIN) -> counted, total_count increments by 1.
- enable = 0 at eop with accept -> counts and table unchanged, fired = 0 after COMMIT.
- clear_all, then packet on stream 5 -> busy high for 64 cycles; eng_state_in = 0; counts retained.
- CNT_W = 4, 17 matching packets -> count 15 with DPI_COUNT_SATURATE_EN, 1 without.
